agu_issue_queue: RTL and testbench
==================================

AGU_ISSUE_QUEUE -- requirements
Module: agu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, operand and immediate width.
REQ-003 SHALL have parameter TAG_W, default 6, CDB and rename tag width.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset). There is one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports flush (in, 1) and disp_valid (in, 1).
REQ-006 SHALL have port disp_ready (out, 1), meaning an entry is free.
REQ-007 SHALL have dispatch payload inputs:
- disp_op1_data / disp_op2_data (DATA_W)
- disp_op1_tag / disp_op2_tag (TAG_W)
- disp_op1_valid / disp_op2_valid (1)
- disp_rd_tag (TAG_W), disp_rd_tag_valid (1)
- disp_funct3 (3), disp_ls (1), disp_imm (DATA_W)
REQ-008 SHALL have CDB inputs cdb_valid (1), cdb_tag (TAG_W) and cdb_data (DATA_W).
REQ-009 SHALL have issue_valid (out, 1) and issue_ready (in, 1).
REQ-010 SHALL have issue payload outputs issue_op1_data, issue_op2_data, issue_rd_tag, issue_rd_tag_valid, issue_funct3, issue_ls and issue_imm, with widths as for dispatch.
REQ-011 SHALL have output count (out, $clog2(DEPTH+1)), the number of occupied entries.

Function
REQ-012 Storage SHALL be a collapsing shift queue. Entry 0 is the oldest. Occupied entries are always contiguous from index 0.
REQ-013 disp_ready SHALL equal (count < DEPTH) and SHALL depend only on registered state.
REQ-014 dispatch_fire = disp_valid & disp_ready. issue_fire = issue_valid & issue_ready.
REQ-015 Issue SHALL be strictly in order: issue_valid = entry0 occupied & op1_valid & op2_valid. A ready younger entry SHALL never issue ahead of entry 0.
REQ-016 Issue payload SHALL be driven combinationally from entry 0 registers. It SHALL be stable while issue_valid=1 and issue_ready=0.
REQ-017 On issue_fire, entries 1..count-1 SHALL shift down one place on the next edge, keeping their operand state.
REQ-018 The dispatched entry SHALL be written at index count, or at index count-1 when issue_fire occurs in the same cycle.
REQ-019 CDB snoop: every occupied entry with opN_valid=0, opN_tag==cdb_tag and cdb_valid=1 SHALL capture cdb_data and set opN_valid=1 on the next edge.
REQ-020 Snoop SHALL apply to entries that are shifting, and SHALL also apply to the entry being dispatched in the same cycle (dispatch-time bypass).
REQ-021 An operand already valid SHALL ignore the CDB.
REQ-022 If both operands of one entry match the same CDB tag, both SHALL capture.
REQ-023 The entry issuing this cycle SHALL ignore the CDB.
REQ-024 Minimum latency SHALL be 1 cycle from dispatch_fire of a fully valid entry into an empty queue to issue_valid=1.
REQ-025 Minimum latency SHALL be 1 cycle from the CDB broadcast that completes entry 0 to issue_valid=1.
REQ-026 Simultaneous dispatch_fire and issue_fire SHALL leave count unchanged.
REQ-027 When full, dispatch SHALL be refused even if issue_fire occurs that cycle.
REQ-028 flush=1 SHALL clear all occupancy and set count=0 on the next edge, with priority over dispatch, issue shift and snoop.
REQ-029 issue_valid SHALL be 0 in the cycle after flush.
REQ-030 Unoccupied entries SHALL never assert issue_valid or capture CDB data.

Reset
REQ-031 rst SHALL clear all entries, occupancy and count to 0 on the next clk edge. rst has priority over flush and all other inputs.
REQ-032 After reset: disp_ready=1, issue_valid=0, count=0, and all issue payload outputs =0.
REQ-033 rst asserted mid-operation SHALL discard all in-flight entries. The first dispatch after rst deasserts SHALL land in entry 0.

Structure
REQ-034 Package agu_queue_pkg SHALL hold the DATA_W and TAG_W defaults and typedef agu_entry_t.
REQ-035 agu_entry_t SHALL contain op1/op2 data, tag and valid; rd_tag and rd_tag_valid; funct3; ls; imm; and occupied.
REQ-036 The per-entry register with CDB snoop and shift/load select SHALL be sub-module agu_queue_entry, instantiated DEPTH times by generate.

Verification
REQ-037 Reset then dispatch {op1_valid=1, op2_valid=1, imm=0x10}. Required: issue_valid=1 the next cycle with issue_imm=0x10, and count=1 until issue_fire.
REQ-038 Dispatch entry A {op1_tag=5, op1_valid=0} and entry B fully valid. Required: B does not issue. After cdb_valid=1, cdb_tag=5, cdb_data=0xDEAD, A issues with op1=0xDEAD, then B issues the next handshake.
REQ-039 Dispatch with op2_tag=9 invalid while cdb_tag=9, cdb_data=0x1234 in the same cycle. Required: the entry stores op2=0x1234 as valid and issues the next cycle.
REQ-040 Fill to DEPTH=4. Required: disp_ready=0. Then issue_fire with disp_valid=1: dispatch refused and count=3. Next cycle, dispatch plus issue together keep count=3.
REQ-041 With 3 entries queued and issue_ready=0, assert flush. Required: count=0, issue_valid=0 and disp_ready=1 next cycle, and a CDB broadcast in the flush cycle is not captured.

Source files
------------

// File: rtl/agu_queue_pkg.sv
// ---------------------------------------------------------------------------
// agu_queue_pkg
// Shared definitions for the AGU issue queue: default operand/tag widths,
// the per-entry record agu_entry_t, and the CDB tag-match helper used by
// every entry.
// ---------------------------------------------------------------------------
package agu_queue_pkg;

    localparam int AGU_DATA_W = 32;
    localparam int AGU_TAG_W  = 6;

    // One reservation slot. 'occupied' marks a live entry; every other field
    // is meaningless while it is 0.
    typedef struct packed {
        logic                  occupied;
        logic [AGU_DATA_W-1:0] op1_data;
        logic [AGU_TAG_W-1:0]  op1_tag;
        logic                  op1_valid;
        logic [AGU_DATA_W-1:0] op2_data;
        logic [AGU_TAG_W-1:0]  op2_tag;
        logic                  op2_valid;
        logic [AGU_TAG_W-1:0]  rd_tag;
        logic                  rd_tag_valid;
        logic [2:0]            funct3;
        logic                  ls;
        logic [AGU_DATA_W-1:0] imm;
    } agu_entry_t;

    // An operand wakes up only while it is still waiting and its producer tag
    // is the one on the CDB this cycle.
    function automatic logic snoop_hit(
        input logic                 op_valid,
        input logic [AGU_TAG_W-1:0] op_tag,
        input logic                 cdb_valid,
        input logic [AGU_TAG_W-1:0] cdb_tag
    );
        return cdb_valid && !op_valid && (op_tag == cdb_tag);
    endfunction

endpackage

// File: rtl/agu_issue_queue_if.sv
// ---------------------------------------------------------------------------
// agu_issue_queue_if
// Bundles the dispatch channel, the CDB broadcast and the issue channel of
// the AGU issue queue.
//   master : dispatch stage / CDB source / AGU (drives disp_*, cdb_*,
//            issue_ready; observes disp_ready and issue_*)
//   slave  : the issue queue itself
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer may not make valid depend on
// ready; while valid=1 and ready=0 the producer holds its payload steady.
// disp_ready depends on registered state only; issue_valid and the issue
// payload come straight from the head entry's registers.
// ---------------------------------------------------------------------------
interface agu_issue_queue_if
    import agu_queue_pkg::*;
#(
    parameter int DATA_W = AGU_DATA_W,
    parameter int TAG_W  = AGU_TAG_W
);
    // dispatch
    logic              disp_valid;
    logic              disp_ready;
    logic [DATA_W-1:0] disp_op1_data;
    logic [DATA_W-1:0] disp_op2_data;
    logic [TAG_W-1:0]  disp_op1_tag;
    logic [TAG_W-1:0]  disp_op2_tag;
    logic              disp_op1_valid;
    logic              disp_op2_valid;
    logic [TAG_W-1:0]  disp_rd_tag;
    logic              disp_rd_tag_valid;
    logic [2:0]        disp_funct3;
    logic              disp_ls;
    logic [DATA_W-1:0] disp_imm;
    // common data bus
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    // issue
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_op1_data;
    logic [DATA_W-1:0] issue_op2_data;
    logic [TAG_W-1:0]  issue_rd_tag;
    logic              issue_rd_tag_valid;
    logic [2:0]        issue_funct3;
    logic              issue_ls;
    logic [DATA_W-1:0] issue_imm;

    modport master (
        output disp_valid, disp_op1_data, disp_op2_data, disp_op1_tag,
               disp_op2_tag, disp_op1_valid, disp_op2_valid, disp_rd_tag,
               disp_rd_tag_valid, disp_funct3, disp_ls, disp_imm,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  disp_ready, issue_valid, issue_op1_data, issue_op2_data,
               issue_rd_tag, issue_rd_tag_valid, issue_funct3, issue_ls,
               issue_imm
    );

    modport slave (
        input  disp_valid, disp_op1_data, disp_op2_data, disp_op1_tag,
               disp_op2_tag, disp_op1_valid, disp_op2_valid, disp_rd_tag,
               disp_rd_tag_valid, disp_funct3, disp_ls, disp_imm,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output disp_ready, issue_valid, issue_op1_data, issue_op2_data,
               issue_rd_tag, issue_rd_tag_valid, issue_funct3, issue_ls,
               issue_imm
    );

endinterface

// File: rtl/agu_queue_entry.sv
// ---------------------------------------------------------------------------
// agu_queue_entry
// One slot of the collapsing issue queue. Each edge it picks its next
// contents from (priority order) the dispatch payload, its younger
// neighbour (queue shifting down), or itself, then lets the CDB wake any
// waiting operand of whatever it picked.
//   clk, rst, flush : clock, sync reset, sync flush (both clear the slot)
//   load            : take load_entry (dispatch lands here)
//   shift           : take shift_entry (head issued, queue collapses)
//   load_entry      : dispatch payload, occupied=1
//   shift_entry     : contents of the next-younger slot
//   cdb_*           : result broadcast
//   entry           : registered slot contents
// ---------------------------------------------------------------------------
module agu_queue_entry
    import agu_queue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load,
    input  logic                  shift,
    input  agu_entry_t            load_entry,
    input  agu_entry_t            shift_entry,
    input  logic                  cdb_valid,
    input  logic [AGU_TAG_W-1:0]  cdb_tag,
    input  logic [AGU_DATA_W-1:0] cdb_data,
    output agu_entry_t            entry
);

    agu_entry_t src;
    agu_entry_t nxt;

    // Snooping the selected source (not the current contents) is what gives
    // shifting entries and the freshly dispatched entry their wakeup. The
    // slot that issues is simply overwritten by its neighbour, so its own
    // snoop result is never kept.
    always_comb begin
        src = entry;
        if (load) begin
            src = load_entry;
        end else if (shift) begin
            src = shift_entry;
        end

        nxt = src;
        if (src.occupied) begin
            if (snoop_hit(src.op1_valid, src.op1_tag, cdb_valid, cdb_tag)) begin
                nxt.op1_data  = cdb_data;
                nxt.op1_valid = 1'b1;
            end
            if (snoop_hit(src.op2_valid, src.op2_tag, cdb_valid, cdb_tag)) begin
                nxt.op2_data  = cdb_data;
                nxt.op2_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            entry <= '0;
        end else begin
            entry <= nxt;
        end
    end

endmodule

// File: rtl/agu_issue_queue.sv
// ---------------------------------------------------------------------------
// agu_issue_queue
// In-order issue queue in front of the address-generation unit. Entries are
// kept in a collapsing shift register, oldest in slot 0, occupied slots
// contiguous from 0. Only slot 0 may issue, once both operands are valid.
// Waiting operands are woken by CDB broadcasts, including in the cycle the
// entry is dispatched.
//   clk   : clock
//   rst   : synchronous active-high reset, highest priority
//   flush : synchronous discard of every entry
//   bus   : dispatch / CDB / issue channels (slave side)
//   count : number of occupied slots
// ---------------------------------------------------------------------------
module agu_issue_queue
    import agu_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = AGU_DATA_W,
    parameter int TAG_W  = AGU_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    agu_issue_queue_if.slave           bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    agu_entry_t       q [DEPTH];
    agu_entry_t       head;
    agu_entry_t       disp_entry;
    logic             dispatch_fire;
    logic             issue_fire;
    logic [CNT_W-1:0] wr_idx;

    assign head = q[0];

    // Registered-only ready: a full queue refuses dispatch even when the
    // head issues in the same cycle.
    assign bus.disp_ready = (count < CNT_W'(DEPTH));
    assign bus.issue_valid = head.occupied && head.op1_valid && head.op2_valid;

    assign dispatch_fire = bus.disp_valid && bus.disp_ready;
    assign issue_fire    = bus.issue_valid && bus.issue_ready;

    // When the head leaves this edge, everything slides down one slot, so the
    // newcomer lands one place lower than the current tail.
    assign wr_idx = count - CNT_W'(issue_fire);

    always_comb begin
        disp_entry              = '0;
        disp_entry.occupied     = 1'b1;
        disp_entry.op1_data     = AGU_DATA_W'(bus.disp_op1_data);
        disp_entry.op1_tag      = AGU_TAG_W'(bus.disp_op1_tag);
        disp_entry.op1_valid    = bus.disp_op1_valid;
        disp_entry.op2_data     = AGU_DATA_W'(bus.disp_op2_data);
        disp_entry.op2_tag      = AGU_TAG_W'(bus.disp_op2_tag);
        disp_entry.op2_valid    = bus.disp_op2_valid;
        disp_entry.rd_tag       = AGU_TAG_W'(bus.disp_rd_tag);
        disp_entry.rd_tag_valid = bus.disp_rd_tag_valid;
        disp_entry.funct3       = bus.disp_funct3;
        disp_entry.ls           = bus.disp_ls;
        disp_entry.imm          = AGU_DATA_W'(bus.disp_imm);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam logic [CNT_W-1:0] IDX = CNT_W'(i);
        agu_entry_t shift_src;

        // The top slot has nobody above it; it shifts in an empty entry.
        if (i == DEPTH - 1) begin : g_top
            assign shift_src = '0;
        end else begin : g_mid
            assign shift_src = q[i+1];
        end

        agu_queue_entry u_entry (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .load        (dispatch_fire && (wr_idx == IDX)),
            .shift       (issue_fire),
            .load_entry  (disp_entry),
            .shift_entry (shift_src),
            .cdb_valid   (bus.cdb_valid),
            .cdb_tag     (AGU_TAG_W'(bus.cdb_tag)),
            .cdb_data    (AGU_DATA_W'(bus.cdb_data)),
            .entry       (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
        end
    end

    assign bus.issue_op1_data     = DATA_W'(head.op1_data);
    assign bus.issue_op2_data     = DATA_W'(head.op2_data);
    assign bus.issue_rd_tag       = TAG_W'(head.rd_tag);
    assign bus.issue_rd_tag_valid = head.rd_tag_valid;
    assign bus.issue_funct3       = head.funct3;
    assign bus.issue_ls           = head.ls;
    assign bus.issue_imm          = DATA_W'(head.imm);

endmodule

// File: tb/tb_agu_issue_queue.sv
module tb_agu_issue_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [2:0] count;

    agu_issue_queue_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    agu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // The queue is a plain ordered list: issue pops the front, dispatch
    // pushes the back, and a CDB broadcast wakes every waiting operand in
    // the list (including the one pushed this cycle).
    typedef struct {
        logic [DATA_W-1:0] d1, d2, imm;
        logic [TAG_W-1:0]  t1, t2, rd;
        logic              v1, v2, rdv, ls;
        logic [2:0]        f3;
    } m_ent_t;

    m_ent_t mq[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        m_ent_t e;
        bit df, ifire;
        if (rst || flush) begin
            mq.delete();
        end else begin
            df    = bus.disp_valid && (mq.size() < DEPTH);
            ifire = bus.issue_ready && (mq.size() > 0) && mq[0].v1 && mq[0].v2;
            if (ifire) void'(mq.pop_front());
            if (df) begin
                e.d1 = bus.disp_op1_data;  e.t1 = bus.disp_op1_tag;  e.v1 = bus.disp_op1_valid;
                e.d2 = bus.disp_op2_data;  e.t2 = bus.disp_op2_tag;  e.v2 = bus.disp_op2_valid;
                e.rd = bus.disp_rd_tag;    e.rdv = bus.disp_rd_tag_valid;
                e.f3 = bus.disp_funct3;    e.ls = bus.disp_ls;       e.imm = bus.disp_imm;
                mq.push_back(e);
            end
            if (bus.cdb_valid) begin
                foreach (mq[k]) begin
                    if (!mq[k].v1 && mq[k].t1 == bus.cdb_tag) begin
                        mq[k].v1 = 1'b1; mq[k].d1 = bus.cdb_data;
                    end
                    if (!mq[k].v2 && mq[k].t2 == bus.cdb_tag) begin
                        mq[k].v2 = 1'b1; mq[k].d2 = bus.cdb_data;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit exp_iv;
        exp_iv = (mq.size() > 0) && mq[0].v1 && mq[0].v2;
        chk("count", 64'(count), 64'(mq.size()));
        chk("disp_ready", 64'(bus.disp_ready), 64'(mq.size() < DEPTH));
        chk("issue_valid", 64'(bus.issue_valid), 64'(exp_iv));
        if (exp_iv) begin
            chk("issue_op1", 64'(bus.issue_op1_data), 64'(mq[0].d1));
            chk("issue_op2", 64'(bus.issue_op2_data), 64'(mq[0].d2));
            chk("issue_imm", 64'(bus.issue_imm), 64'(mq[0].imm));
            chk("issue_rd_tag", 64'(bus.issue_rd_tag), 64'(mq[0].rd));
            chk("issue_rd_v", 64'(bus.issue_rd_tag_valid), 64'(mq[0].rdv));
            chk("issue_f3", 64'(bus.issue_funct3), 64'(mq[0].f3));
            chk("issue_ls", 64'(bus.issue_ls), 64'(mq[0].ls));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.disp_valid = 0;  bus.disp_op1_data = '0; bus.disp_op2_data = '0;
        bus.disp_op1_tag = '0; bus.disp_op2_tag = '0;
        bus.disp_op1_valid = 0; bus.disp_op2_valid = 0;
        bus.disp_rd_tag = '0; bus.disp_rd_tag_valid = 0;
        bus.disp_funct3 = '0; bus.disp_ls = 0; bus.disp_imm = '0;
        bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
        bus.issue_ready = 0; flush = 0;
    endtask

    task automatic set_disp(input logic v1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                            input logic v2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2,
                            input logic [DATA_W-1:0] imm);
        bus.disp_valid = 1;
        bus.disp_op1_valid = v1; bus.disp_op1_tag = t1; bus.disp_op1_data = d1;
        bus.disp_op2_valid = v2; bus.disp_op2_tag = t2; bus.disp_op2_data = d2;
        bus.disp_imm = imm;
        bus.disp_rd_tag = TAG_W'($urandom_range(0, 63));
        bus.disp_rd_tag_valid = 1'($urandom_range(0, 1));
        bus.disp_funct3 = 3'($urandom_range(0, 7));
        bus.disp_ls = 1'($urandom_range(0, 1));
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        bus.cdb_valid = 1; bus.cdb_tag = t; bus.cdb_data = d;
    endtask

    // Inputs are set mid-cycle; one edge is applied and outputs checked at
    // the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        chk("rst_op1", 64'(bus.issue_op1_data), 64'd0);
        chk("rst_op2", 64'(bus.issue_op2_data), 64'd0);
        chk("rst_imm", 64'(bus.issue_imm), 64'd0);
        chk("rst_rd_tag", 64'(bus.issue_rd_tag), 64'd0);
        chk("rst_rd_v", 64'(bus.issue_rd_tag_valid), 64'd0);
        chk("rst_f3", 64'(bus.issue_funct3), 64'd0);
        chk("rst_ls", 64'(bus.issue_ls), 64'd0);

        // single fully valid dispatch into an empty queue
        set_disp(1, 0, 32'hA1, 1, 0, 32'hB2, 32'h10);
        tick();
        idle();
        chk("basic_iv", 64'(bus.issue_valid), 64'd1);
        chk("basic_imm", 64'(bus.issue_imm), 64'h10);
        tick();
        tick();
        chk("basic_hold_cnt", 64'(count), 64'd1);
        bus.issue_ready = 1;
        tick();
        chk("basic_drain", 64'(count), 64'd0);

        // in-order: B must wait behind a blocked A until the CDB wakes A
        idle();
        set_disp(0, 5, 0, 1, 0, 32'h22, 32'h40);
        tick();
        set_disp(1, 0, 32'h33, 1, 0, 32'h44, 32'h50);
        tick();
        idle();
        bus.issue_ready = 1;
        tick();
        chk("order_blocked_iv", 64'(bus.issue_valid), 64'd0);
        chk("order_blocked_cnt", 64'(count), 64'd2);
        set_cdb(5, 32'hDEAD);
        tick();
        bus.cdb_valid = 0;
        chk("order_a_op1", 64'(bus.issue_op1_data), 64'hDEAD);
        chk("order_a_imm", 64'(bus.issue_imm), 64'h40);
        tick();
        chk("order_b_imm", 64'(bus.issue_imm), 64'h50);
        tick();
        chk("order_empty", 64'(count), 64'd0);

        // dispatch-time bypass of a same-cycle CDB broadcast
        idle();
        set_disp(1, 0, 32'h7, 0, 9, 32'h0, 32'h60);
        set_cdb(9, 32'h1234);
        tick();
        idle();
        chk("bypass_op2", 64'(bus.issue_op2_data), 64'h1234);
        chk("bypass_iv", 64'(bus.issue_valid), 64'd1);
        bus.issue_ready = 1;
        tick();

        // full queue refuses dispatch even while issuing
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(1, 0, 32'(i), 1, 0, 32'(i + 100), 32'(i + 200));
            tick();
        end
        idle();
        chk("full_ready", 64'(bus.disp_ready), 64'd0);
        set_disp(1, 0, 32'h1, 1, 0, 32'h2, 32'h300);
        bus.issue_ready = 1;
        tick();
        chk("full_refused_cnt", 64'(count), 64'd3);
        set_disp(1, 0, 32'h3, 1, 0, 32'h4, 32'h301);
        bus.issue_ready = 1;
        tick();
        chk("full_swap_cnt", 64'(count), 64'd3);
        idle();
        bus.issue_ready = 1;
        for (int i = 0; i < DEPTH; i++) tick();

        // flush beats dispatch and CDB capture
        idle();
        for (int i = 0; i < 3; i++) begin
            set_disp(0, 3, 0, 1, 0, 32'(i), 32'(i + 400));
            tick();
        end
        idle();
        flush = 1;
        set_cdb(3, 32'hBEEF);
        set_disp(1, 0, 32'h5, 1, 0, 32'h6, 32'h500);
        tick();
        idle();
        chk("flush_cnt", 64'(count), 64'd0);
        chk("flush_iv", 64'(bus.issue_valid), 64'd0);
        chk("flush_ready", 64'(bus.disp_ready), 64'd1);
        set_disp(0, 3, 0, 1, 0, 32'h9, 32'h600);
        tick();
        idle();
        chk("flush_no_capture", 64'(bus.issue_valid), 64'd0);
        flush = 1;
        tick();
        idle();

        // reset mid-operation discards entries; next dispatch lands in slot 0
        for (int i = 0; i < 2; i++) begin
            set_disp(0, 7, 0, 0, 7, 0, 32'(i + 700));
            tick();
        end
        idle();
        rst = 1;
        tick();
        rst = 0;
        set_disp(1, 0, 32'h11, 1, 0, 32'h12, 32'h77);
        tick();
        idle();
        chk("rst_mid_imm", 64'(bus.issue_imm), 64'h77);
        chk("rst_mid_cnt", 64'(count), 64'd1);

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 99) < 60)
                set_disp(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom,
                         1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), $urandom,
                         $urandom);
            if ($urandom_range(0, 99) < 40)
                set_cdb(TAG_W'($urandom_range(0, 7)), $urandom);
            bus.issue_ready = 1'($urandom_range(0, 99) < 55);
            flush = 1'($urandom_range(0, 99) < 2);
            rst = 1'($urandom_range(0, 199) < 1);
            tick();
            rst = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
